// File: rtl/led_seq_pkg.sv
// Shared types and pattern helpers for the LED pattern sequencer.
// Optional button debounce is enabled with LED_SEQ_DEBOUNCE_EN.
package led_seq_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_EVEN  = 3'd1,
    MODE_ODD   = 3'd2,
    MODE_ALT   = 3'd3,
    MODE_CHASE = 3'd4
  } mode_e;

  localparam int MODE_COUNT = 5;
  localparam int MAX_LEDS   = 64;

  function automatic logic [MAX_LEDS-1:0] even_pattern(input int n);
    logic [MAX_LEDS-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_LEDS; i += 2) begin
      if (i < n) p[i] = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [MAX_LEDS-1:0] odd_pattern(input int n);
    logic [MAX_LEDS-1:0] p;
    p = '0;
    for (int i = 1; i < MAX_LEDS; i += 2) begin
      if (i < n) p[i] = 1'b1;
    end
    return p;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    unique case (m)
      MODE_IDLE:  n = MODE_EVEN;
      MODE_EVEN:  n = MODE_ODD;
      MODE_ODD:   n = MODE_ALT;
      MODE_ALT:   n = MODE_CHASE;
      MODE_CHASE: n = MODE_IDLE;
      default:    n = MODE_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_button_conditioner.sv
// Button synchronizer, optional debouncer and rising-edge press pulse.
// Debounce stage is present only when LED_SEQ_DEBOUNCE_EN is defined.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 200_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  logic sync0_q, sync0_d;
  logic sync1_q, sync1_d;
  logic prev_q, prev_d;

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;

  // Accept the new level on the edge that completes the stable run.
  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    if (sync1_q != acc_q) begin
      if (cnt_q == CNT_LAST) acc_d = sync1_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign level = acc_q;
`else
  logic unused_dbc;
  assign unused_dbc = |DEBOUNCE_CYCLES;
  assign level      = sync1_q;
`endif

  always_comb begin
    sync0_d = raw;
    sync1_d = sync0_q;
    prev_d  = level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      prev_q  <= prev_d;
    end
  end

  assign press = level & ~prev_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Two-button LED bank sequencer: mode FSM, pause, prescaler, patterns.
// Define LED_SEQ_DEBOUNCE_EN to debounce both buttons.
module led_pattern_sequencer #(
  parameter int NUM_LEDS        = 10,
  parameter int TICK_DIV        = 5_000_000,
  parameter int DEBOUNCE_CYCLES = 200_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                button1,
  input  logic                button2,
  output logic [NUM_LEDS-1:0] oleds,
  output logic [2:0]          mode,
  output logic                paused
);

  import led_seq_pkg::*;

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(NUM_LEDS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] POS_LAST   = SW'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] EVEN_PAT =
    NUM_LEDS'(even_pattern(NUM_LEDS));
  localparam logic [NUM_LEDS-1:0] ODD_PAT =
    NUM_LEDS'(odd_pattern(NUM_LEDS));
  localparam logic [NUM_LEDS-1:0] ONE_HOT0 = NUM_LEDS'(1);

  logic b1_level, b1_press;
  logic b2_level, b2_press;
  logic unused_levels;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn1 (
    .clk  (clk),
    .reset(reset),
    .raw  (button1),
    .level(b1_level),
    .press(b1_press)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn2 (
    .clk  (clk),
    .reset(reset),
    .raw  (button2),
    .level(b2_level),
    .press(b2_press)
  );

  assign unused_levels = b1_level ^ b2_level;

  mode_e               mode_q, mode_d;
  logic                paused_q, paused_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                phase_q, phase_d;
  logic [SW-1:0]       pos_q, pos_d;
  logic [NUM_LEDS-1:0] oleds_q, oleds_d;
  logic                adv, toggle, tick;

  always_comb begin
    adv      = b1_press;
    toggle   = b2_press & ~b1_press;
    tick     = ~paused_q && (presc_q == PRESC_LAST);
    mode_d   = mode_q;
    paused_d = paused_q;
    presc_d  = presc_q;
    phase_d  = phase_q;
    pos_d    = pos_q;
    if (adv) begin
      mode_d   = next_mode(mode_q);
      paused_d = 1'b0;
      presc_d  = '0;
      phase_d  = 1'b0;
      pos_d    = '0;
    end else begin
      if (toggle)    paused_d = ~paused_q;
      if (!paused_q) presc_d  = tick ? '0 : presc_q + 1'b1;
      if (tick && mode_q == MODE_ALT) phase_d = ~phase_q;
      if (tick && mode_q == MODE_CHASE)
        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
    end
  end

  // Pattern comes from next-state so oleds never lags mode.
  always_comb begin
    oleds_d = '0;
    unique case (mode_d)
      MODE_IDLE:  oleds_d = '0;
      MODE_EVEN:  oleds_d = EVEN_PAT;
      MODE_ODD:   oleds_d = ODD_PAT;
      MODE_ALT:   oleds_d = phase_d ? ODD_PAT : EVEN_PAT;
      MODE_CHASE: oleds_d = ONE_HOT0 << pos_d;
      default:    oleds_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_IDLE;
      paused_q <= 1'b0;
      presc_q  <= '0;
      phase_q  <= 1'b0;
      pos_q    <= '0;
      oleds_q  <= '0;
    end else begin
      mode_q   <= mode_d;
      paused_q <= paused_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      pos_q    <= pos_d;
      oleds_q  <= oleds_d;
    end
  end

  assign oleds  = oleds_q;
  assign mode   = mode_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (N=10, div=4, db=3).
// Reference model tracks elapsed run cycles and derives patterns from them.
module tb_led_pattern_sequencer;

  localparam int N  = 10;
  localparam int TD = 4;
  localparam int DB = 3;
`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         button1 = 1'b0;
  logic         button2 = 1'b0;
  logic [N-1:0] oleds;
  logic [2:0]   mode;
  logic         paused;

  int passed = 0;
  int total  = 0;

  led_pattern_sequencer #(
    .NUM_LEDS(N),
    .TICK_DIV(TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .button1(button1),
    .button2(button2),
    .oleds  (oleds),
    .mode   (mode),
    .paused (paused)
  );

  always #5 clk = ~clk;

  // Model: mode, pause flag, and unpaused cycles since last mode change.
  int m_mode = 0;
  int m_run  = 0;
  bit m_paused = 1'b0;
  bit rawp[2];
  bit syn[2];
  bit acc[2];
  bit pend[2];
`ifdef LED_SEQ_DEBOUNCE_EN
  bit hist0[$];
  bit hist1[$];

  function automatic bit stable_diff(input bit q[$], input bit a);
    if (q.size() < DB) return 1'b0;
    for (int i = 0; i < DB; i++)
      if (q[q.size()-1-i] == a) return 1'b0;
    return 1'b1;
  endfunction
`endif

  function automatic logic [N-1:0] exp_leds(input int md, input int run);
    int st;
    logic [N-1:0] one;
    one = 1;
    st  = run / TD;
    case (md)
      1: return 10'h155;
      2: return 10'h2AA;
      3: return (st % 2 == 1) ? 10'h2AA : 10'h155;
      4: return one << (st % N);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit p1, p2, raw, nsync, old;
    if (reset) begin
      m_mode = 0; m_run = 0; m_paused = 1'b0;
      for (int b = 0; b < 2; b++) begin
        rawp[b] = 0; syn[b] = 0; acc[b] = 0; pend[b] = 0;
      end
`ifdef LED_SEQ_DEBOUNCE_EN
      hist0.delete();
      hist1.delete();
`endif
    end else begin
      p1 = pend[0];
      p2 = pend[1] & ~pend[0];
      if (p1) begin
        m_mode = (m_mode + 1) % 5;
        m_paused = 1'b0;
        m_run = 0;
      end else begin
        if (!m_paused) m_run++;
        if (p2) m_paused = ~m_paused;
      end
      for (int b = 0; b < 2; b++) begin
        raw = (b == 0) ? button1 : button2;
        nsync = rawp[b];
        rawp[b] = raw;
        old = acc[b];
`ifdef LED_SEQ_DEBOUNCE_EN
        if (b == 0) begin
          hist0.push_back(syn[0]);
          if (hist0.size() > DB) void'(hist0.pop_front());
          if (stable_diff(hist0, acc[0])) acc[0] = ~acc[0];
        end else begin
          hist1.push_back(syn[1]);
          if (hist1.size() > DB) void'(hist1.pop_front());
          if (stable_diff(hist1, acc[1])) acc[1] = ~acc[1];
        end
`else
        acc[b] = nsync;
`endif
        syn[b] = nsync;
        pend[b] = acc[b] & ~old;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    check("model", 32'({mode, paused, oleds}),
          32'({3'(m_mode), m_paused, exp_leds(m_mode, m_run)}));
  endtask

  task automatic release_btns();
    button1 = 1'b0;
    button2 = 1'b0;
    repeat (LAT + 1) cyc();
  endtask

  task automatic tap(input bit b1, input bit b2);
    button1 = b1;
    button2 = b2;
    repeat (LAT) cyc();
    release_btns();
  endtask

  typedef struct {
    bit         b1;
    bit         b2;
    int         md;
    bit         pz;
    logic [9:0] leds;
    bit         chk;
  } vec_t;

  vec_t vecs[13];
  int   prev_md;
  int   found;
  logic [N-1:0] frozen;

  initial begin
    vecs[0]  = '{1, 0, 1, 0, 10'h155, 1};
    vecs[1]  = '{1, 0, 2, 0, 10'h2AA, 1};
    vecs[2]  = '{1, 0, 3, 0, 10'h155, 1};
    vecs[3]  = '{1, 0, 4, 0, 10'h001, 1};
    vecs[4]  = '{1, 0, 0, 0, 10'h000, 1};
    vecs[5]  = '{0, 1, 0, 1, 10'h000, 1};
    vecs[6]  = '{0, 1, 0, 0, 10'h000, 1};
    vecs[7]  = '{1, 0, 1, 0, 10'h155, 1};
    vecs[8]  = '{1, 0, 2, 0, 10'h2AA, 1};
    vecs[9]  = '{1, 0, 3, 0, 10'h155, 1};
    vecs[10] = '{0, 1, 3, 1, 10'h000, 0};
    vecs[11] = '{1, 1, 4, 0, 10'h001, 1};
    vecs[12] = '{1, 0, 0, 0, 10'h000, 1};

    reset = 1'b1;
    repeat (2) cyc();
    check("rst_oleds", 32'(oleds), 32'h0);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_paused", 32'(paused), 32'h0);
    reset = 1'b0;
    repeat (20) begin
      cyc();
      check("idle", 32'({mode, paused, oleds}), 32'h0);
    end

    prev_md = 0;
    for (int i = 0; i < 13; i++) begin
      button1 = vecs[i].b1;
      button2 = vecs[i].b2;
      repeat (LAT - 1) cyc();
      check("early_mode", 32'(mode), 32'(prev_md));
      cyc();
      check("vec_mode", 32'(mode), 32'(vecs[i].md));
      check("vec_paused", 32'(paused), 32'(vecs[i].pz));
      if (vecs[i].chk) check("vec_leds", 32'(oleds), 32'(vecs[i].leds));
      prev_md = vecs[i].md;
      release_btns();
    end

    repeat (3) tap(1, 0);
    button1 = 1'b1;
    repeat (LAT) cyc();
    check("chase_mode", 32'(mode), 32'd4);
    for (int k = 0; k <= 44; k++) begin
      if (k > 0) cyc();
      if (k == 2) button1 = 1'b0;
      check("chase_step", 32'(oleds), 32'(10'd1 << ((k / TD) % N)));
    end
    repeat (LAT) cyc();
    button2 = 1'b1;
    repeat (LAT) cyc();
    check("pause_on", 32'(paused), 32'd1);
    frozen = exp_leds(m_mode, m_run);
    button2 = 1'b0;
    repeat (20) begin
      cyc();
      check("frozen", 32'(oleds), 32'(frozen));
    end
    tap(0, 1);
    check("pause_off", 32'(paused), 32'd0);
    repeat (12) cyc();

`ifdef LED_SEQ_DEBOUNCE_EN
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    button1 = 1; repeat (2) cyc();
    button1 = 0; cyc();
    button1 = 1; repeat (2) cyc();
    button1 = 0; repeat (12) cyc();
    check("bounce_mode", 32'(mode), 32'd0);
    button1 = 1; repeat (5) cyc();
    button1 = 0; repeat (12) cyc();
    check("held_mode", 32'(mode), 32'd1);
`endif

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (3) tap(1, 0);
    found = 0;
    for (int w = 0; w < 2 * TD && found == 0; w++) begin
      if (!m_paused && (m_run % TD) == TD - 1) found = 1;
      else cyc();
    end
    check("tick_found", 32'(found), 32'd1);
    check("alt_mode", 32'(mode), 32'd3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midrst_oleds", 32'(oleds), 32'h0);
    check("midrst_mode", 32'(mode), 32'h0);
    tap(1, 0);
    tap(1, 0);
    tap(1, 0);
    tap(1, 0);
    repeat (10) cyc();

    for (int r = 0; r < 3000; r++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 11) == 0) button1 = ~button1;
      if ($urandom_range(0, 11) == 0) button2 = ~button2;
      cyc();
    end
    reset = 1'b0;
    release_btns();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
